window_watchdog_core: RTL and testbench

- Windowed watchdog timing engine, directly downstream of the watchdog configuration register.
- Consumes FWLEN (closed-window length), SWLEN (open-window length), RST_LMT, WDSRVC and INIT.
- Times the closed/open window sequence, classifies each service event as good or early, and detects timeouts.
- Counts faults and issues a fixed-length system reset request when the fault limit is reached.

---
 rtl/window_watchdog_core.sv | 149 ++++++++++++++
 tb/tb_window_watchdog_core.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/window_watchdog_core.sv
// Windowed watchdog timing engine: times closed/open service windows, classifies
// service events, counts faults and raises a fixed-length reset request at the fault limit.
module window_watchdog_core #(
    parameter int RST_PULSE = 16,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [CNT_W-1:0] FWLEN,
    input  logic [CNT_W-1:0] SWLEN,
    input  logic [CNT_W-1:0] RST_LMT,
    input  logic             WDSRVC,
    input  logic             INIT,
    output logic             WDRST,
    output logic             FAULT,
    output logic             SVC_OK,
    output logic [2:0]       FLCODE,
    output logic [CNT_W-1:0] FAULT_CNT,
    output logic [1:0]       STATE
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_CLOSED    = 2'b01,
        S_OPEN      = 2'b10,
        S_FAULT_RST = 2'b11
    } state_t;

    localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

    state_t           state;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] win_len;
    logic [PW-1:0]    pulse_cnt;
    logic             svc_prev;

    logic             svc;
    logic             last_cycle;
    logic             early;
    logic             timeout;
    logic [CNT_W-1:0] fault_cnt_inc;
    logic             limit_hit;

    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
        return (len == '0) ? CNT_W'(1) : len;
    endfunction

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        svc           = WDSRVC & ~svc_prev;
        last_cycle    = (win_cnt == win_len - CNT_W'(1));
        early         = (state == S_CLOSED) && !INIT && svc;
        timeout       = (state == S_OPEN) && !INIT && !svc && last_cycle;
        fault_cnt_inc = (&FAULT_CNT) ? FAULT_CNT : FAULT_CNT + CNT_W'(1);
        limit_hit     = (RST_LMT != '0) && (fault_cnt_inc >= RST_LMT);
    end

    assign STATE = state;

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            win_cnt   <= '0;
            win_len   <= CNT_W'(1);
            pulse_cnt <= '0;
            svc_prev  <= 1'b0;
            WDRST     <= 1'b0;
            FAULT     <= 1'b0;
            SVC_OK    <= 1'b0;
            FLCODE    <= '0;
            FAULT_CNT <= '0;
        end else begin
            svc_prev <= WDSRVC;
            FAULT    <= 1'b0;
            SVC_OK   <= 1'b0;

            if (early || timeout) begin
                FAULT     <= 1'b1;
                FAULT_CNT <= fault_cnt_inc;
                if (early) FLCODE[0] <= 1'b1;
                else       FLCODE[1] <= 1'b1;
                if (limit_hit) begin
                    state     <= S_FAULT_RST;
                    FLCODE[2] <= 1'b1;
                    WDRST     <= 1'b1;
                    pulse_cnt <= '0;
                end else begin
                    state   <= S_CLOSED;
                    win_cnt <= '0;
                    win_len <= eff_len(FWLEN);
                end
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (!INIT) begin
                            state   <= S_CLOSED;
                            win_cnt <= '0;
                            win_len <= eff_len(FWLEN);
                        end
                    end
                    S_CLOSED: begin
                        if (INIT) begin
                            state   <= S_IDLE;
                            win_cnt <= '0;
                        end else if (last_cycle) begin
                            state   <= S_OPEN;
                            win_cnt <= '0;
                            win_len <= eff_len(SWLEN);
                        end else begin
                            win_cnt <= win_cnt + CNT_W'(1);
                        end
                    end
                    S_OPEN: begin
                        if (INIT) begin
                            state   <= S_IDLE;
                            win_cnt <= '0;
                        end else if (svc) begin
                            state   <= S_CLOSED;
                            win_cnt <= '0;
                            win_len <= eff_len(FWLEN);
                            SVC_OK  <= 1'b1;
                        end else begin
                            win_cnt <= win_cnt + CNT_W'(1);
                        end
                    end
                    S_FAULT_RST: begin
                        // Service edges and INIT are deliberately ignored until the pulse ends.
                        if (pulse_cnt == PW'(RST_PULSE - 1)) begin
                            WDRST     <= 1'b0;
                            FAULT_CNT <= '0;
                            win_cnt   <= '0;
                            if (INIT) begin
                                state <= S_IDLE;
                            end else begin
                                state   <= S_CLOSED;
                                win_len <= eff_len(FWLEN);
                            end
                        end else begin
                            pulse_cnt <= pulse_cnt + PW'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_window_watchdog_core.sv
// Directed bench for window_watchdog_core: windows, early/timeout faults, reset pulse, boundaries.
module tb_window_watchdog_core;

    localparam int CNT_W     = 16;
    localparam int RST_PULSE = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic [CNT_W-1:0] FWLEN, SWLEN, RST_LMT;
    logic             WDSRVC, INIT;
    logic             WDRST, FAULT, SVC_OK;
    logic [2:0]       FLCODE;
    logic [CNT_W-1:0] FAULT_CNT;
    logic [1:0]       STATE;

    int checks = 0;
    int errors = 0;

    window_watchdog_core #(.RST_PULSE(RST_PULSE), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .FWLEN(FWLEN), .SWLEN(SWLEN), .RST_LMT(RST_LMT),
        .WDSRVC(WDSRVC), .INIT(INIT), .WDRST(WDRST), .FAULT(FAULT), .SVC_OK(SVC_OK),
        .FLCODE(FLCODE), .FAULT_CNT(FAULT_CNT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    // Advance n rising edges; inputs are driven and outputs sampled 1 ns after each edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; INIT = 1'b1; WDSRVC = 1'b0;
        step(1);
        RST = 1'b0;
    endtask

    // Leave IDLE: after one edge the core sits in CLOSED with win_cnt=0.
    task automatic start_window();
        INIT = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        FWLEN = 16'd4; SWLEN = 16'd3; RST_LMT = 16'd0;
        RST = 1'b1; INIT = 1'b1; WDSRVC = 1'b0;
        step(2);
        checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", STATE); end
        checks++; if (FLCODE !== 3'b000) begin errors++; $display("FAIL reset_flcode got %b exp 000", FLCODE); end
        checks++; if (FAULT_CNT !== 16'd0) begin errors++; $display("FAIL reset_fault_cnt got %0d exp 0", FAULT_CNT); end
        checks++; if ({WDRST, FAULT, SVC_OK} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {WDRST, FAULT, SVC_OK}); end
        RST = 1'b0;
    endtask

    task automatic test_good_service();
        do_reset();
        FWLEN = 16'd4; SWLEN = 16'd3; RST_LMT = 16'd0;
        start_window();
        for (int i = 0; i < 4; i++) begin
            checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL good_closed%0d STATE got %0d exp 1", i, STATE); end
            step(1);
        end
        checks++; if (STATE !== 2'd2) begin errors++; $display("FAIL good_open0 STATE got %0d exp 2", STATE); end
        step(1);
        checks++; if (STATE !== 2'd2) begin errors++; $display("FAIL good_open1 STATE got %0d exp 2", STATE); end
        WDSRVC = 1'b1;
        step(1);
        checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL good_back STATE got %0d exp 1", STATE); end
        checks++; if (SVC_OK !== 1'b1) begin errors++; $display("FAIL good_svc_ok got %b exp 1", SVC_OK); end
        checks++; if (FAULT !== 1'b0) begin errors++; $display("FAIL good_fault got %b exp 0", FAULT); end
        step(1);
        checks++; if (SVC_OK !== 1'b0) begin errors++; $display("FAIL good_svc_ok_width got %b exp 0", SVC_OK); end
        checks++; if (FLCODE !== 3'b000) begin errors++; $display("FAIL good_flcode got %b exp 000", FLCODE); end
        WDSRVC = 1'b0;
    endtask

    task automatic test_early();
        do_reset();
        FWLEN = 16'd4; SWLEN = 16'd3; RST_LMT = 16'd0;
        start_window();
        step(1);
        WDSRVC = 1'b1;
        step(1);
        checks++; if (FAULT !== 1'b1) begin errors++; $display("FAIL early_fault got %b exp 1", FAULT); end
        checks++; if (FLCODE !== 3'b001) begin errors++; $display("FAIL early_flcode got %b exp 001", FLCODE); end
        checks++; if (FAULT_CNT !== 16'd1) begin errors++; $display("FAIL early_cnt got %0d exp 1", FAULT_CNT); end
        checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL early_state got %0d exp 1", STATE); end
        step(1);
        checks++; if (FAULT !== 1'b0) begin errors++; $display("FAIL early_fault_width got %b exp 0", FAULT); end
        step(2);
        checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL early_restart_closed got %0d exp 1", STATE); end
        step(1);
        checks++; if (STATE !== 2'd2) begin errors++; $display("FAIL early_restart_open got %0d exp 2", STATE); end
        WDSRVC = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        FWLEN = 16'd4; SWLEN = 16'd3; RST_LMT = 16'd0;
        start_window();
        step(6);
        checks++; if (STATE !== 2'd2 || FAULT !== 1'b0) begin errors++; $display("FAIL to_last_open got state %0d fault %b exp 2/0", STATE, FAULT); end
        step(1);
        checks++; if (FAULT !== 1'b1) begin errors++; $display("FAIL to_fault1 got %b exp 1", FAULT); end
        checks++; if (FLCODE !== 3'b010) begin errors++; $display("FAIL to_flcode got %b exp 010", FLCODE); end
        checks++; if (FAULT_CNT !== 16'd1) begin errors++; $display("FAIL to_cnt1 got %0d exp 1", FAULT_CNT); end
        checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL to_state got %0d exp 1", STATE); end
        step(7);
        checks++; if (FAULT !== 1'b1 || FAULT_CNT !== 16'd2) begin errors++; $display("FAIL to_cnt2 got fault %b cnt %0d exp 1/2", FAULT, FAULT_CNT); end
        step(7);
        checks++; if (FAULT !== 1'b1 || FAULT_CNT !== 16'd3) begin errors++; $display("FAIL to_cnt3 got fault %b cnt %0d exp 1/3", FAULT, FAULT_CNT); end
    endtask

    task automatic test_limit();
        do_reset();
        FWLEN = 16'd4; SWLEN = 16'd3; RST_LMT = 16'd2;
        start_window();
        step(7);
        checks++; if (FAULT_CNT !== 16'd1 || STATE !== 2'd1) begin errors++; $display("FAIL lim_first got cnt %0d state %0d exp 1/1", FAULT_CNT, STATE); end
        step(7);
        checks++; if (STATE !== 2'd3) begin errors++; $display("FAIL lim_state got %0d exp 3", STATE); end
        checks++; if (FLCODE !== 3'b110) begin errors++; $display("FAIL lim_flcode got %b exp 110", FLCODE); end
        checks++; if (FAULT_CNT !== 16'd2) begin errors++; $display("FAIL lim_cnt got %0d exp 2", FAULT_CNT); end
        checks++; if (WDRST !== 1'b1 || FAULT !== 1'b1) begin errors++; $display("FAIL lim_pulse0 got wdrst %b fault %b exp 1/1", WDRST, FAULT); end
        for (int i = 1; i < RST_PULSE; i++) begin
            WDSRVC = (i % 2) == 1;
            step(1);
            checks++; if (WDRST !== 1'b1) begin errors++; $display("FAIL lim_pulse%0d WDRST got %b exp 1", i, WDRST); end
        end
        WDSRVC = 1'b0;
        step(1);
        checks++; if (WDRST !== 1'b0) begin errors++; $display("FAIL lim_pulse_end WDRST got %b exp 0", WDRST); end
        checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL lim_after_state got %0d exp 1", STATE); end
        checks++; if (FAULT_CNT !== 16'd0) begin errors++; $display("FAIL lim_after_cnt got %0d exp 0", FAULT_CNT); end
        checks++; if (FLCODE !== 3'b110 || SVC_OK !== 1'b0) begin errors++; $display("FAIL lim_svc_ignored got flcode %b svc_ok %b exp 110/0", FLCODE, SVC_OK); end
        RST_LMT = 16'd0;
    endtask

    task automatic test_level_service();
        do_reset();
        FWLEN = 16'd4; SWLEN = 16'd3; RST_LMT = 16'd0;
        start_window();
        step(4);
        WDSRVC = 1'b1;
        step(1);
        checks++; if (SVC_OK !== 1'b1) begin errors++; $display("FAIL lvl_first_svc got %b exp 1", SVC_OK); end
        step(6);
        checks++; if (STATE !== 2'd2) begin errors++; $display("FAIL lvl_held_open got %0d exp 2", STATE); end
        step(1);
        checks++; if (FAULT !== 1'b1 || SVC_OK !== 1'b0) begin errors++; $display("FAIL lvl_held_timeout got fault %b svc_ok %b exp 1/0", FAULT, SVC_OK); end
        WDSRVC = 1'b0;
        step(6);
        WDSRVC = 1'b1;
        step(1);
        checks++; if (SVC_OK !== 1'b1 || FAULT !== 1'b0) begin errors++; $display("FAIL lvl_last_open_svc got svc_ok %b fault %b exp 1/0", SVC_OK, FAULT); end
        checks++; if (FAULT_CNT !== 16'd1 || STATE !== 2'd1) begin errors++; $display("FAIL lvl_after got cnt %0d state %0d exp 1/1", FAULT_CNT, STATE); end
        WDSRVC = 1'b0;
    endtask

    task automatic test_boundaries();
        do_reset();
        FWLEN = 16'd0; SWLEN = 16'd0; RST_LMT = 16'd0;
        start_window();
        step(1);
        checks++; if (STATE !== 2'd2) begin errors++; $display("FAIL bnd_zero_open got %0d exp 2", STATE); end
        step(1);
        checks++; if (STATE !== 2'd1 || FAULT !== 1'b1) begin errors++; $display("FAIL bnd_zero_timeout got state %0d fault %b exp 1/1", STATE, FAULT); end
        step(1);
        checks++; if (STATE !== 2'd2 || FAULT !== 1'b0) begin errors++; $display("FAIL bnd_zero_reopen got state %0d fault %b exp 2/0", STATE, FAULT); end

        do_reset();
        FWLEN = 16'd4; SWLEN = 16'd3;
        start_window();
        step(1);
        FWLEN = 16'd8;
        step(2);
        checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL bnd_midchg_closed got %0d exp 1", STATE); end
        step(1);
        checks++; if (STATE !== 2'd2) begin errors++; $display("FAIL bnd_midchg_open got %0d exp 2", STATE); end
        step(3);
        checks++; if (FAULT !== 1'b1 || FAULT_CNT !== 16'd1) begin errors++; $display("FAIL bnd_midchg_timeout got fault %b cnt %0d exp 1/1", FAULT, FAULT_CNT); end
        step(7);
        checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL bnd_newlen_closed got %0d exp 1", STATE); end
        step(1);
        checks++; if (STATE !== 2'd2) begin errors++; $display("FAIL bnd_newlen_open got %0d exp 2", STATE); end

        step(1);
        INIT = 1'b1; WDSRVC = 1'b1;
        step(1);
        checks++; if (STATE !== 2'd0 || SVC_OK !== 1'b0) begin errors++; $display("FAIL bnd_init_idle got state %0d svc_ok %b exp 0/0", STATE, SVC_OK); end
        checks++; if (FAULT_CNT !== 16'd1 || FLCODE !== 3'b010) begin errors++; $display("FAIL bnd_init_retain got cnt %0d flcode %b exp 1/010", FAULT_CNT, FLCODE); end

        WDSRVC = 1'b0; RST_LMT = 16'd1; INIT = 1'b0;
        step(1);
        WDSRVC = 1'b1;
        step(1);
        checks++; if (STATE !== 2'd3 || WDRST !== 1'b1 || FLCODE !== 3'b111) begin errors++; $display("FAIL bnd_rst_enter got state %0d wdrst %b flcode %b exp 3/1/111", STATE, WDRST, FLCODE); end
        step(1);
        RST = 1'b1;
        step(1);
        checks++; if (STATE !== 2'd0 || WDRST !== 1'b0 || FLCODE !== 3'b000 || FAULT_CNT !== 16'd0) begin
            errors++; $display("FAIL bnd_rst_mid_pulse got state %0d wdrst %b flcode %b cnt %0d exp 0/0/000/0", STATE, WDRST, FLCODE, FAULT_CNT);
        end
        RST = 1'b0; WDSRVC = 1'b0; RST_LMT = 16'd0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout bench did not finish within 1 ms");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_good_service();
        test_early();
        test_timeout();
        test_limit();
        test_level_service();
        test_boundaries();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
